down_count_timer: RTL and testbench

//   Loadable synchronous down-counter/timer: the counting-down counterpart of the

---
 rtl/down_count_timer.sv | 113 +++++++++++
 tb/tb_down_count_timer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/down_count_timer.sv
// Loadable synchronous down-counter/timer with terminal-count flag,
// sticky done flag and optional auto-reload from a captured reload value.
module down_count_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             busy_reg, busy_next;
  logic             tc_reg, tc_next;
  logic             done_reg, done_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      q_reg      <= '0;
      reload_reg <= '0;
      busy_reg   <= 1'b0;
      tc_reg     <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      q_reg      <= q_next;
      reload_reg <= reload_next;
      busy_reg   <= busy_next;
      tc_reg     <= tc_next;
      done_reg   <= done_next;
    end
  end

  // tc defaults low: it is only raised on the edge where q steps 1->0 in RUN.
  always_comb begin
    state_next  = state_reg;
    q_next      = q_reg;
    reload_next = reload_reg;
    tc_next     = 1'b0;
    done_next   = done_reg;

    if (load) begin
      q_next      = load_val;
      reload_next = load_val;
      state_next  = IDLE;
      done_next   = 1'b0;
    end else if (stop) begin
      if (state_reg == RUN) begin
        state_next = IDLE;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (q_reg != '0) begin
              state_next = RUN;
            end else begin
              state_next = DONE;
              done_next  = 1'b1;
            end
          end
        end
        RUN: begin
          if (q_reg != '0) begin
            q_next  = q_reg - WIDTH'(1);
            tc_next = (q_reg == WIDTH'(1));
          end else if (auto_reload && (reload_reg != '0)) begin
            q_next = reload_reg;
          end else begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            q_next = reload_reg;
            if (reload_reg != '0) begin
              state_next = RUN;
              done_next  = 1'b0;
            end else begin
              done_next = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end

    busy_next = (state_next == RUN);
  end

  assign q    = q_reg;
  assign busy = busy_reg;
  assign tc   = tc_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_down_count_timer.sv
// Directed self-checking bench for down_count_timer (WIDTH=4).
module tb_down_count_timer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc;
  logic             done;

  int asserts;
  int failures;

  down_count_timer #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_val(load_val),
    .start(start),
    .stop(stop),
    .auto_reload(auto_reload),
    .q(q),
    .busy(busy),
    .tc(tc),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0; auto_reload = 1'b0;
    tick(); tick();
    reset = 1'b0;
    asserts++;
    if (q !== 4'd0) begin failures++; $display("FAIL reset_q: got %0d expected 0", q); end
    asserts++;
    if ({busy, tc, done} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {busy, tc, done}); end
    $display("test_reset: q=%0d busy=%b tc=%b done=%b", q, busy, tc, done);
  endtask

  task automatic test_one_shot();
    load = 1'b1; load_val = 4'd5; tick(); load = 1'b0;
    asserts++;
    if (q !== 4'd5 || {busy, tc, done} !== 3'b000) begin failures++; $display("FAIL oneshot_load: got q=%0d flags=%b expected q=5 flags=000", q, {busy, tc, done}); end
    start = 1'b1; tick(); start = 1'b0;
    asserts++;
    if (q !== 4'd5 || {busy, tc, done} !== 3'b100) begin failures++; $display("FAIL oneshot_start: got q=%0d flags=%b expected q=5 flags=100", q, {busy, tc, done}); end
    for (int k = 4; k >= 0; k--) begin
      tick();
      asserts++;
      if (q !== 4'(k) || {busy, tc, done} !== {1'b1, (k == 0), 1'b0}) begin
        failures++;
        $display("FAIL oneshot_count: got q=%0d flags=%b expected q=%0d flags=%b", q, {busy, tc, done}, k, {1'b1, (k == 0), 1'b0});
      end
    end
    tick();
    asserts++;
    if (q !== 4'd0 || {busy, tc, done} !== 3'b001) begin failures++; $display("FAIL oneshot_done: got q=%0d flags=%b expected q=0 flags=001", q, {busy, tc, done}); end
    start = 1'b1; tick(); start = 1'b0;
    asserts++;
    if (q !== 4'd5 || {busy, tc, done} !== 3'b100) begin failures++; $display("FAIL done_restart: got q=%0d flags=%b expected q=5 flags=100", q, {busy, tc, done}); end
    $display("test_one_shot: q=%0d busy=%b tc=%b done=%b", q, busy, tc, done);
  endtask

  task automatic test_auto_reload();
    auto_reload = 1'b1;
    load = 1'b1; load_val = 4'd3; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    asserts++;
    if (q !== 4'd3 || {busy, tc, done} !== 3'b100) begin failures++; $display("FAIL reload_start: got q=%0d flags=%b expected q=3 flags=100", q, {busy, tc, done}); end
    for (int k = 1; k <= 10; k++) begin
      int exp_q;
      exp_q = 3 - (k % 4);
      tick();
      asserts++;
      if (q !== 4'(exp_q) || {busy, tc, done} !== {1'b1, (exp_q == 0), 1'b0}) begin
        failures++;
        $display("FAIL reload_count: cycle %0d got q=%0d flags=%b expected q=%0d flags=%b", k, q, {busy, tc, done}, exp_q, {1'b1, (exp_q == 0), 1'b0});
      end
    end
    auto_reload = 1'b0;
    $display("test_auto_reload: q=%0d busy=%b tc=%b done=%b", q, busy, tc, done);
  endtask

  task automatic test_stop_resume();
    load = 1'b1; load_val = 4'd6; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 5; k >= 2; k--) tick();
    asserts++;
    if (q !== 4'd2 || busy !== 1'b1) begin failures++; $display("FAIL stop_pre: got q=%0d busy=%b expected q=2 busy=1", q, busy); end
    stop = 1'b1; tick(); stop = 1'b0;
    asserts++;
    if (q !== 4'd2 || {busy, tc, done} !== 3'b000) begin failures++; $display("FAIL stop_hold: got q=%0d flags=%b expected q=2 flags=000", q, {busy, tc, done}); end
    tick();
    asserts++;
    if (q !== 4'd2 || {busy, tc, done} !== 3'b000) begin failures++; $display("FAIL stop_hold2: got q=%0d flags=%b expected q=2 flags=000", q, {busy, tc, done}); end
    start = 1'b1; tick(); start = 1'b0;
    asserts++;
    if (q !== 4'd2 || {busy, tc, done} !== 3'b100) begin failures++; $display("FAIL resume_start: got q=%0d flags=%b expected q=2 flags=100", q, {busy, tc, done}); end
    tick();
    asserts++;
    if (q !== 4'd1 || {busy, tc, done} !== 3'b100) begin failures++; $display("FAIL resume_q1: got q=%0d flags=%b expected q=1 flags=100", q, {busy, tc, done}); end
    tick();
    asserts++;
    if (q !== 4'd0 || {busy, tc, done} !== 3'b110) begin failures++; $display("FAIL resume_q0: got q=%0d flags=%b expected q=0 flags=110", q, {busy, tc, done}); end
    tick();
    asserts++;
    if (q !== 4'd0 || {busy, tc, done} !== 3'b001) begin failures++; $display("FAIL resume_done: got q=%0d flags=%b expected q=0 flags=001", q, {busy, tc, done}); end
    $display("test_stop_resume: q=%0d busy=%b tc=%b done=%b", q, busy, tc, done);
  endtask

  task automatic test_load_while_running();
    load = 1'b1; load_val = 4'd8; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    asserts++;
    if (q !== 4'd4 || busy !== 1'b1) begin failures++; $display("FAIL reload_pre: got q=%0d busy=%b expected q=4 busy=1", q, busy); end
    load = 1'b1; load_val = 4'd9; tick(); load = 1'b0;
    asserts++;
    if (q !== 4'd9 || {busy, tc, done} !== 3'b000) begin failures++; $display("FAIL run_load: got q=%0d flags=%b expected q=9 flags=000", q, {busy, tc, done}); end
    tick();
    asserts++;
    if (q !== 4'd9 || {busy, tc, done} !== 3'b000) begin failures++; $display("FAIL run_load_idle: got q=%0d flags=%b expected q=9 flags=000", q, {busy, tc, done}); end
    $display("test_load_while_running: q=%0d busy=%b tc=%b done=%b", q, busy, tc, done);
  endtask

  task automatic test_reset_mid_run();
    load = 1'b1; load_val = 4'd15; tick(); load = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    asserts++;
    if (q !== 4'd15 || busy !== 1'b1) begin failures++; $display("FAIL max_start: got q=%0d busy=%b expected q=15 busy=1", q, busy); end
    repeat (8) tick();
    asserts++;
    if (q !== 4'd7 || busy !== 1'b1) begin failures++; $display("FAIL max_count: got q=%0d busy=%b expected q=7 busy=1", q, busy); end
    reset = 1'b1; tick(); reset = 1'b0;
    asserts++;
    if (q !== 4'd0 || {busy, tc, done} !== 3'b000) begin failures++; $display("FAIL midrun_reset: got q=%0d flags=%b expected q=0 flags=000", q, {busy, tc, done}); end
    tick(); tick();
    asserts++;
    if (q !== 4'd0 || {busy, tc, done} !== 3'b000) begin failures++; $display("FAIL midrun_reset_hold: got q=%0d flags=%b expected q=0 flags=000", q, {busy, tc, done}); end
    $display("test_reset_mid_run: q=%0d busy=%b tc=%b done=%b", q, busy, tc, done);
  endtask

  task automatic test_zero_and_start_stop();
    start = 1'b1; tick(); start = 1'b0;
    asserts++;
    if (q !== 4'd0 || {busy, tc, done} !== 3'b001) begin failures++; $display("FAIL zero_start: got q=%0d flags=%b expected q=0 flags=001", q, {busy, tc, done}); end
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    asserts++;
    if (q !== 4'd0 || {busy, tc, done} !== 3'b001) begin failures++; $display("FAIL done_startstop: got q=%0d flags=%b expected q=0 flags=001", q, {busy, tc, done}); end
    start = 1'b1; tick(); start = 1'b0;
    asserts++;
    if (q !== 4'd0 || {busy, tc, done} !== 3'b001) begin failures++; $display("FAIL done_zero_reload: got q=%0d flags=%b expected q=0 flags=001", q, {busy, tc, done}); end
    load = 1'b1; load_val = 4'd2; tick(); load = 1'b0;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    asserts++;
    if (q !== 4'd2 || {busy, tc, done} !== 3'b000) begin failures++; $display("FAIL idle_startstop: got q=%0d flags=%b expected q=2 flags=000", q, {busy, tc, done}); end
    $display("test_zero_and_start_stop: q=%0d busy=%b tc=%b done=%b", q, busy, tc, done);
  endtask

  initial begin
    asserts  = 0;
    failures = 0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_stop_resume();
    test_load_while_running();
    test_reset_mid_run();
    test_zero_and_start_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
